// File: rtl/rgbw_frame_ctrl_if.sv
// Byte-receiver bus into the RGBW frame sequencer plus its committed PWM register outputs.
// The receiver side drives cs/byte_rdy/byte_data; the sequencer drives everything else.
interface rgbw_frame_ctrl_if;
    logic       cs;
    logic       byte_rdy;
    logic [7:0] byte_data;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic [7:0] white;
    logic [7:0] bright;
    logic       update;
    logic       frame_err;
    logic       busy;

    modport master (
        output cs, byte_rdy, byte_data,
        input  red, green, blue, white, bright, update, frame_err, busy
    );

    modport slave (
        input  cs, byte_rdy, byte_data,
        output red, green, blue, white, bright, update, frame_err, busy
    );
endinterface

// File: rtl/rgbw_frame_ctrl.sv
// Parses framed SPI commands and commits staged payloads atomically to the RGBW/brightness registers.
// Outputs load one cycle after the final byte_rdy rise; there is no backpressure, so bytes arriving in DISCARD are dropped.
module rgbw_frame_ctrl #(
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] BRIGHT_RST  = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    rgbw_frame_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DATA, DISCARD} state_t;

    localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic        rdy_q;
    logic        accept;
    logic [3:0]  opcode;
    logic        op_ok;
    logic [1:0]  op_q;
    logic [1:0]  chan_q;
    logic [1:0]  cnt;
    logic [15:0] tcnt;
    logic [7:0]  stage [4];
    logic        last_byte;
    logic        tc_hit;
    logic        start;
    logic        stage_we;
    logic        commit;
    logic        abort;
    logic [7:0]  red_q, green_q, blue_q, white_q, bright_q;
    logic        update_q, err_q, busy_q;

    // cs low gates acceptance, so a byte_rdy rise coinciding with cs high is dropped.
    assign accept    = bus.byte_rdy & ~rdy_q & ~bus.cs;
    assign opcode    = bus.byte_data[7:4];
    assign op_ok     = (opcode == 4'h1) || (opcode == 4'h2) || (opcode == 4'h3);
    assign last_byte = (op_q == 2'd1) ? (cnt == 2'd3) : (cnt == 2'd0);
    assign tc_hit    = (tcnt == TC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = op_ok ? DATA : DISCARD;
            end
            DATA: begin
                if (bus.cs)                    state_nxt = IDLE;
                else if (accept && last_byte)  state_nxt = IDLE;
                else if (!accept && tc_hit)    state_nxt = DISCARD;
            end
            DISCARD: begin
                if (bus.cs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A final accept on the terminal-count cycle commits rather than timing out.
    always_comb begin
        start    = 1'b0;
        stage_we = 1'b0;
        commit   = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                start = accept & op_ok;
                abort = accept & ~op_ok;
            end
            DATA: begin
                stage_we = accept;
                commit   = accept & last_byte;
                abort    = bus.cs | (~accept & tc_hit);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q    <= 1'b0;
            op_q     <= 2'd0;
            chan_q   <= 2'd0;
            cnt      <= 2'd0;
            tcnt     <= 16'd0;
            for (int i = 0; i < 4; i++) stage[i] <= 8'd0;
            red_q    <= 8'd0;
            green_q  <= 8'd0;
            blue_q   <= 8'd0;
            white_q  <= 8'd0;
            bright_q <= BRIGHT_RST;
            update_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q    <= bus.byte_rdy;
            update_q <= commit;
            err_q    <= abort;
            busy_q   <= (state_nxt == DATA);

            if (start) begin
                op_q   <= opcode[1:0];
                chan_q <= bus.byte_data[1:0];
                cnt    <= 2'd0;
                tcnt   <= 16'd0;
            end else if (state == DATA) begin
                if (accept) begin
                    cnt  <= cnt + 2'd1;
                    tcnt <= 16'd0;
                end else begin
                    tcnt <= tcnt + 16'd1;
                end
            end else begin
                tcnt <= 16'd0;
            end

            if (abort) begin
                for (int i = 0; i < 4; i++) stage[i] <= 8'd0;
            end else if (stage_we) begin
                stage[cnt] <= bus.byte_data;
            end

            // The last payload byte is taken straight from the bus rather than from staging.
            if (commit) begin
                case (op_q)
                    2'd1: begin
                        red_q   <= stage[0];
                        green_q <= stage[1];
                        blue_q  <= stage[2];
                        white_q <= bus.byte_data;
                    end
                    2'd2: bright_q <= bus.byte_data;
                    2'd3: begin
                        case (chan_q)
                            2'd0:    red_q   <= bus.byte_data;
                            2'd1:    green_q <= bus.byte_data;
                            2'd2:    blue_q  <= bus.byte_data;
                            default: white_q <= bus.byte_data;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.red       = red_q;
    assign bus.green     = green_q;
    assign bus.blue      = blue_q;
    assign bus.white     = white_q;
    assign bus.bright    = bright_q;
    assign bus.update    = update_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_rgbw_frame_ctrl.sv
// Directed bench for rgbw_frame_ctrl with a short inter-byte timeout (16 cycles).
module tb_rgbw_frame_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   upd_cnt = 0;
    int   err_cnt = 0;
    int   both_cnt = 0;
    int   u0, e0;
    logic s_upd, s_err, s_busy;

    rgbw_frame_ctrl_if bus();

    rgbw_frame_ctrl #(.TIMEOUT_CYC(16), .BRIGHT_RST(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.update)                  upd_cnt++;
            if (bus.frame_err)               err_cnt++;
            if (bus.update && bus.frame_err) both_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // byte_rdy high for two cycles; flags are sampled in the cycle after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bus.byte_data = b;
        bus.byte_rdy  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_upd  = bus.update;
        s_err  = bus.frame_err;
        s_busy = bus.busy;
        @(posedge clk); #1;
        bus.byte_rdy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rgbw();
        return {bus.red, bus.green, bus.blue, bus.white};
    endfunction

    initial begin
        bus.cs = 1'b1;
        bus.byte_rdy = 1'b0;
        bus.byte_data = 8'h00;
        idle(3);
        check("rst_rgbw", rgbw(), 32'h0);
        check("rst_bright", {24'h0, bus.bright}, 32'hFF);
        check("rst_flags", {29'h0, bus.update, bus.frame_err, bus.busy}, 32'h0);
        reset = 1'b0;
        idle(2);

        // WRITE_RGBW
        bus.cs = 1'b0;
        u0 = upd_cnt; e0 = err_cnt;
        send_byte(8'h10);
        check("t1_busy_b1", {31'h0, s_busy}, 32'h1);
        check("t1_upd_b1", {31'h0, s_upd}, 32'h0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("t1_busy_b4", {31'h0, s_busy}, 32'h1);
        check("t1_rgbw_pre", rgbw(), 32'h0);
        send_byte(8'h44);
        check("t1_upd_b5", {31'h0, s_upd}, 32'h1);
        check("t1_busy_b5", {31'h0, s_busy}, 32'h0);
        idle(2);
        check("t1_rgbw", rgbw(), 32'h11223344);
        check("t1_upd_cnt", upd_cnt - u0, 1);
        check("t1_err_cnt", err_cnt - e0, 0);

        // WRITE_CHAN blue then WRITE_BRIGHT back to back
        u0 = upd_cnt;
        send_byte(8'h32);
        send_byte(8'h80);
        check("t2_upd_chan", {31'h0, s_upd}, 32'h1);
        check("t2_rgbw_chan", rgbw(), 32'h11228044);
        send_byte(8'h20);
        send_byte(8'h40);
        idle(1);
        check("t2_bright", {24'h0, bus.bright}, 32'h40);
        check("t2_rgbw", rgbw(), 32'h11228044);
        check("t2_upd_cnt", upd_cnt - u0, 2);

        // cs high mid-payload
        u0 = upd_cnt; e0 = err_cnt;
        send_byte(8'h10);
        send_byte(8'hAA);
        send_byte(8'hBB);
        bus.cs = 1'b1;
        idle(3);
        check("t3_err_cnt", err_cnt - e0, 1);
        check("t3_upd_cnt", upd_cnt - u0, 0);
        check("t3_rgbw", rgbw(), 32'h11228044);
        check("t3_busy", {31'h0, bus.busy}, 32'h0);
        bus.cs = 1'b0;
        send_byte(8'h31);
        send_byte(8'h55);
        idle(1);
        check("t3_green", rgbw(), 32'h11558044);

        // unknown opcode discards rest of window
        u0 = upd_cnt; e0 = err_cnt;
        send_byte(8'h70);
        check("t4_err_pulse", {31'h0, s_err}, 32'h1);
        send_byte(8'h10);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("t4_ignored", rgbw(), 32'h11558044);
        check("t4_upd_none", upd_cnt - u0, 0);
        bus.cs = 1'b1;
        idle(2);
        bus.cs = 1'b0;
        send_byte(8'h10);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        idle(1);
        check("t4_rgbw", rgbw(), 32'h01020304);
        check("t4_err_cnt", err_cnt - e0, 1);

        // timeout: 16 idle edges after the last accept aborts
        u0 = upd_cnt; e0 = err_cnt;
        send_byte(8'h10);
        send_byte(8'h01);
        idle(13);
        @(negedge clk);
        check("t5_no_err_early", {31'h0, bus.frame_err}, 32'h0);
        @(negedge clk);
        check("t5_err_at_tc", {31'h0, bus.frame_err}, 32'h1);
        check("t5_busy", {31'h0, bus.busy}, 32'h0);
        @(posedge clk); #1;
        check("t5_err_cnt", err_cnt - e0, 1);
        check("t5_upd_cnt", upd_cnt - u0, 0);
        check("t5_rgbw", rgbw(), 32'h01020304);
        bus.cs = 1'b1;
        idle(2);
        bus.cs = 1'b0;

        // 15 idle edges then the next byte: accept wins
        u0 = upd_cnt; e0 = err_cnt;
        send_byte(8'h10);
        send_byte(8'h05);
        idle(13);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        idle(1);
        check("t5b_rgbw", rgbw(), 32'h05060708);
        check("t5b_err_cnt", err_cnt - e0, 0);
        check("t5b_upd_cnt", upd_cnt - u0, 1);

        // async reset mid-frame
        u0 = upd_cnt; e0 = err_cnt;
        send_byte(8'h10);
        send_byte(8'h0A);
        send_byte(8'h0B);
        reset = 1'b1;
        #1;
        check("t6_rgbw", rgbw(), 32'h0);
        check("t6_bright", {24'h0, bus.bright}, 32'hFF);
        check("t6_flags", {29'h0, bus.update, bus.frame_err, bus.busy}, 32'h0);
        idle(2);
        reset = 1'b0;
        idle(2);
        send_byte(8'h20);
        send_byte(8'h33);
        check("t6_idle_after", {31'h0, s_upd}, 32'h1);
        idle(1);
        check("t6_bright_new", {24'h0, bus.bright}, 32'h33);
        check("t6_rgbw_hold", rgbw(), 32'h0);
        check("t6_err_cnt", err_cnt - e0, 0);
        check("t6_upd_cnt", upd_cnt - u0, 1);

        check("upd_err_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
